// File: rtl/norm_shift_left.sv
// Two-stage left normalizer: stage 1 captures the operand and its leading-zero count,
// stage 2 shifts and adjusts the exponent. Define NORM_SHIFT_LEFT_DENORM_EN for the denormal clamp.
module norm_shift_left #(
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 5,
  parameter int EXP_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_mant,
  input  logic [EXP_WIDTH-1:0]    in_exp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_mant,
  output logic [EXP_WIDTH-1:0]    out_exp,
  output logic [SELECT_WIDTH-1:0] shift_num,
  output logic                    out_zero,
  output logic                    out_uflow
);

  localparam int XW = EXP_WIDTH + 1;

  logic                    v1;
  logic                    v2;
  logic                    adv1;
  logic                    adv2;

  logic [DATA_WIDTH-1:0]   mant1;
  logic [EXP_WIDTH-1:0]    exp1;
  logic [SELECT_WIDTH-1:0] lzc1;
  logic                    zero1;

  logic [SELECT_WIDTH-1:0] lzc_in;
  logic                    zero_in;
  logic                    found;

  logic [XW-1:0]           exp_diff;
  logic                    borrow;
  logic [DATA_WIDTH-1:0]   mant_n;
  logic [EXP_WIDTH-1:0]    exp_n;
  logic [SELECT_WIDTH-1:0] shift_n;
  logic                    zero_n;
  logic                    uflow_n;

  // A stage moves forward when it is empty or its consumer is taking its contents.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  assign zero_in = ~|in_mant;

  always_comb begin
    lzc_in = '0;
    found  = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (!found && in_mant[i]) begin
        lzc_in = SELECT_WIDTH'(DATA_WIDTH - 1 - i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      mant1 <= '0;
      exp1  <= '0;
      lzc1  <= '0;
      zero1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        mant1 <= in_mant;
        exp1  <= in_exp;
        lzc1  <= lzc_in;
        zero1 <= zero_in;
      end
    end
  end

  // The extra exponent bit turns into a borrow flag when the shift would take the exponent negative.
  always_comb begin
    exp_diff = {1'b0, exp1} - XW'(lzc1);
    borrow   = exp_diff[XW-1];
    mant_n   = mant1 << lzc1;
    exp_n    = exp_diff[EXP_WIDTH-1:0];
    shift_n  = lzc1;
    zero_n   = 1'b0;
    uflow_n  = 1'b0;
    if (zero1) begin
      mant_n  = '0;
      exp_n   = '0;
      shift_n = '0;
      zero_n  = 1'b1;
    end else if (borrow) begin
      exp_n   = '0;
      uflow_n = 1'b1;
`ifdef NORM_SHIFT_LEFT_DENORM_EN
      mant_n  = mant1 << exp1;
      shift_n = exp1[SELECT_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      shift_num <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_mant  <= mant_n;
        out_exp   <= exp_n;
        shift_num <= shift_n;
        out_zero  <= zero_n;
        out_uflow <= uflow_n;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_left.sv
// Self-checking bench for norm_shift_left: directed vector table, stall/reset sequences,
// and randomized handshaking checked against a shift-until-normalized reference model.
`timescale 1ns/1ps
module tb_norm_shift_left;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [SW-1:0] shift_num;
  logic          out_zero;
  logic          out_uflow;

  typedef struct {
    logic [DW-1:0] mant;
    logic [EW-1:0] exp;
    logic [SW-1:0] shift;
    logic          zero;
    logic          uflow;
  } res_t;

  typedef struct {
    logic [DW-1:0] in_mant;
    logic [EW-1:0] in_exp;
    res_t          want;
  } vec_t;

  int      n_checks = 0;
  int      n_pass   = 0;
  res_t    exp_q[$];
  res_t    popped;
  bit      mon_en = 1'b0;
  bit      stall_prev = 1'b0;
  bit      saw_full = 1'b0;
  logic [47:0] snap = '0;
  vec_t    vecs[9];

  norm_shift_left #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .shift_num(shift_num), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic compareResult(string tag, res_t w);
    checkOutput({tag, "_mant"}, 64'(out_mant), 64'(w.mant));
    checkOutput({tag, "_exp"}, 64'(out_exp), 64'(w.exp));
    checkOutput({tag, "_shift"}, 64'(shift_num), 64'(w.shift));
    checkOutput({tag, "_zero"}, 64'(out_zero), 64'(w.zero));
    checkOutput({tag, "_uflow"}, 64'(out_uflow), 64'(w.uflow));
  endtask

  // Normalize by shifting one bit at a time until the MSB is set.
  function automatic res_t refModel(logic [DW-1:0] mant, logic [EW-1:0] e);
    res_t r;
    int lz;
    logic [DW-1:0] m;
    r.mant = '0; r.exp = '0; r.shift = '0; r.zero = 1'b0; r.uflow = 1'b0;
    if (mant == '0) begin
      r.zero = 1'b1;
      return r;
    end
    lz = 0;
    m  = mant;
    while (!m[DW-1]) begin
      m = m << 1;
      lz++;
    end
    if (lz <= int'(e)) begin
      r.mant  = m;
      r.exp   = EW'(int'(e) - lz);
      r.shift = SW'(lz);
    end else begin
      r.uflow = 1'b1;
`ifdef NORM_SHIFT_LEFT_DENORM_EN
      r.mant  = mant << e;
      r.shift = SW'(e);
`else
      r.mant  = m;
      r.shift = SW'(lz);
`endif
    end
    return r;
  endfunction

  function automatic vec_t mkVec(logic [DW-1:0] im, logic [EW-1:0] ie, logic [DW-1:0] om,
                                 logic [EW-1:0] oe, logic [SW-1:0] sh, logic z, logic u);
    vec_t v;
    v.in_mant = im; v.in_exp = ie;
    v.want.mant = om; v.want.exp = oe; v.want.shift = sh; v.want.zero = z; v.want.uflow = u;
    return v;
  endfunction

  // Scoreboard: every released result must match the oldest accepted operand.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (stall_prev)
        checkOutput("stall_hold", 64'({out_valid, out_zero, out_uflow, shift_num, out_exp, out_mant}),
                    64'(snap));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_result", 64'(1), 64'(0));
        end else begin
          popped = exp_q.pop_front();
          compareResult("stream", popped);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(refModel(in_mant, in_exp));
      stall_prev = out_valid && !out_ready;
      snap = {out_valid, out_zero, out_uflow, shift_num, out_exp, out_mant};
    end
  end

  task automatic randOperand();
    logic [DW-1:0] m;
    m = $urandom;
    case ($urandom_range(0, 5))
      0:       m = '0;
      1:       m = m >> $urandom_range(16, 31);
      default: m = m >> $urandom_range(0, 31);
    endcase
    in_mant = m;
    in_exp  = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 40)) : EW'($urandom_range(0, 255));
  endtask

  task automatic applyVector(vec_t v, string tag);
    int lat;
    in_valid = 1'b1;
    in_mant  = v.in_mant;
    in_exp   = v.in_exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(1));
    compareResult(tag, v.want);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(int n, bit rand_hs, int stall_start, int stall_len);
    int sent = 0;
    int cyc = 0;
    bit fire;
    in_valid = 1'b1;
    randOperand();
    while (sent < n && cyc < 20 * n + 50) begin
      if (rand_hs) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      @(negedge clk);
      fire = in_valid && in_ready;
      if (!in_ready) saw_full = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (fire) sent++;
      if (fire || !in_valid) begin
        if (sent < n) begin
          in_valid = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
          randOperand();
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checkOutput("all_sent", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    @(posedge clk); #1;
    checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));
    checkOutput("idle_valid", 64'(out_valid), 64'(0));
  endtask

  initial begin
    vecs[0] = mkVec(32'h0000_0001, 8'd100, 32'h8000_0000, 8'd69, 5'd31, 1'b0, 1'b0);
    vecs[1] = mkVec(32'h0000_0000, 8'd50,  32'h0000_0000, 8'd0,  5'd0,  1'b1, 1'b0);
    vecs[2] = mkVec(32'h8000_0000, 8'd0,   32'h8000_0000, 8'd0,  5'd0,  1'b0, 1'b0);
    vecs[3] = mkVec(32'h0000_F000, 8'd16,  32'hF000_0000, 8'd0,  5'd16, 1'b0, 1'b0);
    vecs[4] = mkVec(32'h1234_5678, 8'd255, 32'h91A2_B3C0, 8'd252, 5'd3, 1'b0, 1'b0);
    vecs[5] = mkVec(32'h0000_0000, 8'd0,   32'h0000_0000, 8'd0,  5'd0,  1'b1, 1'b0);
`ifdef NORM_SHIFT_LEFT_DENORM_EN
    vecs[6] = mkVec(32'h0001_0000, 8'd5,   32'h0020_0000, 8'd0,  5'd5,  1'b0, 1'b1);
    vecs[7] = mkVec(32'h0000_F000, 8'd15,  32'h7800_0000, 8'd0,  5'd15, 1'b0, 1'b1);
    vecs[8] = mkVec(32'h0000_0001, 8'd0,   32'h0000_0001, 8'd0,  5'd0,  1'b0, 1'b1);
`else
    vecs[6] = mkVec(32'h0001_0000, 8'd5,   32'h8000_0000, 8'd0,  5'd15, 1'b0, 1'b1);
    vecs[7] = mkVec(32'h0000_F000, 8'd15,  32'hF000_0000, 8'd0,  5'd16, 1'b0, 1'b1);
    vecs[8] = mkVec(32'h0000_0001, 8'd0,   32'h8000_0000, 8'd0,  5'd31, 1'b0, 1'b1);
`endif

    // Reset state while held and after release.
    #3;
    checkOutput("reset_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_outs", 64'({out_zero, out_uflow, shift_num, out_exp, out_mant}), 64'(0));
    checkOutput("reset_ready", 64'(in_ready), 64'(1));
    #9 rst_n = 1'b1;
    #1 checkOutput("post_reset_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) applyVector(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] back-to-back stream with mid-stream stall");
    mon_en = 1'b1;
    saw_full = 1'b0;
    applyStimulus(8, 1'b0, 3, 3);
    drain();
    checkOutput("in_ready_low_when_full", 64'(saw_full), 64'(1));

    $display("[TB] randomized handshaking");
    applyStimulus(150, 1'b1, 0, 0);
    drain();
    mon_en = 1'b0;
    stall_prev = 1'b0;

    $display("[TB] reset with operands in flight");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = 32'h0000_00FF;
    in_exp    = 8'd60;
    @(posedge clk); #1;
    in_mant = 32'h0F00_0000;
    in_exp  = 8'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("pre_reset_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 64'(out_valid), 64'(0));
    checkOutput("async_outs", 64'({out_zero, out_uflow, shift_num, out_exp, out_mant}), 64'(0));
    checkOutput("async_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("no_ghost%0d", i), 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    applyVector(vecs[0], "recover");

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
